// File: rtl/mem_access_pkg.sv
// Shared encodings for the data-memory access unit.
// Holds the memory command encodings driven on mem_rwen_o, the RV32I
// load/store funct3 values, the response fault codes, the FSM state type
// and a small helper that tells store commands apart from load commands.
package mem_access_pkg;

  // Memory command encodings
  localparam logic [3:0] RWEN_IDLE = 4'b0000;
  localparam logic [3:0] RWEN_LB   = 4'b1000;
  localparam logic [3:0] RWEN_LH   = 4'b1001;
  localparam logic [3:0] RWEN_LW   = 4'b1010;
  localparam logic [3:0] RWEN_LBU  = 4'b1100;
  localparam logic [3:0] RWEN_LHU  = 4'b1101;
  localparam logic [3:0] RWEN_SB   = 4'b1011;
  localparam logic [3:0] RWEN_SH   = 4'b1110;
  localparam logic [3:0] RWEN_SW   = 4'b1111;

  // RV32I funct3 values shared by loads and stores
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Response fault codes
  localparam logic [1:0] FAULT_NONE     = 2'b00;
  localparam logic [1:0] FAULT_MISALIGN = 2'b01;
  localparam logic [1:0] FAULT_RANGE    = 2'b10;
  localparam logic [1:0] FAULT_FUNCT3   = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_ACCESS = 2'b01,
    ST_RESP   = 2'b10
  } state_e;

  // Store commands are the only ones whose response data must read as zero.
  function automatic logic is_store(input logic [3:0] rwen);
    return (rwen == RWEN_SB) || (rwen == RWEN_SH) || (rwen == RWEN_SW);
  endfunction

endpackage

// File: rtl/mem_req_check.sv
// Combinational request decoder for the memory access unit.
// Turns a load/store request into its memory command and reports the
// highest-priority fault (illegal funct3 > misaligned > out of range).
// Ports:
//   we_i      1 = store, 0 = load
//   funct3_i  RV32I funct3 of the access
//   addr_i    byte address
//   rwen_o    memory command (RWEN_IDLE when funct3 is illegal)
//   fault_o   fault code, FAULT_NONE when the access may proceed
module mem_req_check
  import mem_access_pkg::*;
#(
  parameter int unsigned MEM_BYTES = 524288
) (
  input  logic        we_i,
  input  logic [2:0]  funct3_i,
  input  logic [31:0] addr_i,
  output logic [3:0]  rwen_o,
  output logic [1:0]  fault_o
);

  localparam logic [32:0] MEM_LIMIT = 33'(MEM_BYTES);

  logic        legal;
  logic [32:0] size;
  logic [32:0] last_byte;

  // Decode funct3 into a command and access size. The last byte touched is
  // formed in 33 bits so addresses near 0xFFFFFFFF cannot wrap back into range.
  always_comb begin
    rwen_o    = RWEN_IDLE;
    legal     = 1'b1;
    size      = 33'd1;
    fault_o   = FAULT_NONE;
    if (we_i) begin
      case (funct3_i)
        F3_B:    begin rwen_o = RWEN_SB; size = 33'd1; end
        F3_H:    begin rwen_o = RWEN_SH; size = 33'd2; end
        F3_W:    begin rwen_o = RWEN_SW; size = 33'd4; end
        default: legal = 1'b0;
      endcase
    end else begin
      case (funct3_i)
        F3_B:    begin rwen_o = RWEN_LB;  size = 33'd1; end
        F3_H:    begin rwen_o = RWEN_LH;  size = 33'd2; end
        F3_W:    begin rwen_o = RWEN_LW;  size = 33'd4; end
        F3_BU:   begin rwen_o = RWEN_LBU; size = 33'd1; end
        F3_HU:   begin rwen_o = RWEN_LHU; size = 33'd2; end
        default: legal = 1'b0;
      endcase
    end

    last_byte = {1'b0, addr_i} + size - 33'd1;

    if (!legal) begin
      fault_o = FAULT_FUNCT3;
    end else if ((size == 33'd2 && addr_i[0]) ||
                 (size == 33'd4 && addr_i[1:0] != 2'b00)) begin
      fault_o = FAULT_MISALIGN;
    end else if (last_byte >= MEM_LIMIT) begin
      fault_o = FAULT_RANGE;
    end
  end

endmodule

// File: rtl/mem_access_unit.sv
// Initiator side of the data-memory byte interface.
// Accepts one load/store at a time, checks it, drives the memory command
// for exactly one cycle and returns the (already extended) read data on a
// valid/ready response channel. Every output comes straight from a register.
// Ports:
//   clk_i, reset_i               clock, synchronous active-high reset
//   req_valid_i / req_ready_o    request handshake
//   req_we_i, req_funct3_i       access kind
//   req_addr_i, req_wdata_i      byte address, right-justified store data
//   rsp_valid_o / rsp_ready_i    response handshake
//   rsp_rdata_o, rsp_fault_o     load data (0 for stores/faults), fault code
//   mem_rwen_o, mem_address_o,
//   mem_writedata_o              memory command, address and store data
//   mem_readdata_i               combinational memory read data
module mem_access_unit
  import mem_access_pkg::*;
#(
  parameter int unsigned MEM_BYTES = 524288
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_we_i,
  input  logic [2:0]  req_funct3_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_rdata_o,
  output logic [1:0]  rsp_fault_o,
  output logic [3:0]  mem_rwen_o,
  output logic [31:0] mem_address_o,
  output logic [31:0] mem_writedata_o,
  input  logic [31:0] mem_readdata_i
);

  state_e      state_q, state_d;
  logic        req_ready_q, req_ready_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;
  logic [1:0]  rsp_fault_q, rsp_fault_d;
  logic [3:0]  mem_rwen_q, mem_rwen_d;
  logic [31:0] mem_address_q, mem_address_d;
  logic [31:0] mem_writedata_q, mem_writedata_d;

  logic [3:0]  chk_rwen;
  logic [1:0]  chk_fault;

  mem_req_check #(
    .MEM_BYTES(MEM_BYTES)
  ) u_check (
    .we_i    (req_we_i),
    .funct3_i(req_funct3_i),
    .addr_i  (req_addr_i),
    .rwen_o  (chk_rwen),
    .fault_o (chk_fault)
  );

  // Next-state logic. Everything holds by default; a faulting request skips
  // ACCESS so the memory never sees a command for it. The memory command is
  // dropped at the edge that closes ACCESS, which is also where load data is
  // captured from the combinational read port.
  always_comb begin
    state_d         = state_q;
    req_ready_d     = req_ready_q;
    rsp_valid_d     = rsp_valid_q;
    rsp_rdata_d     = rsp_rdata_q;
    rsp_fault_d     = rsp_fault_q;
    mem_rwen_d      = mem_rwen_q;
    mem_address_d   = mem_address_q;
    mem_writedata_d = mem_writedata_q;

    case (state_q)
      ST_IDLE: begin
        if (req_valid_i) begin
          req_ready_d = 1'b0;
          rsp_rdata_d = 32'h0;
          rsp_fault_d = chk_fault;
          if (chk_fault != FAULT_NONE) begin
            rsp_valid_d = 1'b1;
            state_d     = ST_RESP;
          end else begin
            mem_rwen_d      = chk_rwen;
            mem_address_d   = req_addr_i;
            mem_writedata_d = req_wdata_i;
            state_d         = ST_ACCESS;
          end
        end
      end
      ST_ACCESS: begin
        mem_rwen_d  = RWEN_IDLE;
        rsp_valid_d = 1'b1;
        rsp_rdata_d = is_store(mem_rwen_q) ? 32'h0 : mem_readdata_i;
        state_d     = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_ready_i) begin
          rsp_valid_d = 1'b0;
          req_ready_d = 1'b1;
          state_d     = ST_IDLE;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        req_ready_d = 1'b1;
        rsp_valid_d = 1'b0;
        mem_rwen_d  = RWEN_IDLE;
      end
    endcase
  end

  // State and output registers. Reset clears everything, including a
  // pending response; a store already on the bus still commits because the
  // memory samples the registered command at this same edge.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q         <= ST_IDLE;
      req_ready_q     <= 1'b1;
      rsp_valid_q     <= 1'b0;
      rsp_rdata_q     <= 32'h0;
      rsp_fault_q     <= FAULT_NONE;
      mem_rwen_q      <= RWEN_IDLE;
      mem_address_q   <= 32'h0;
      mem_writedata_q <= 32'h0;
    end else begin
      state_q         <= state_d;
      req_ready_q     <= req_ready_d;
      rsp_valid_q     <= rsp_valid_d;
      rsp_rdata_q     <= rsp_rdata_d;
      rsp_fault_q     <= rsp_fault_d;
      mem_rwen_q      <= mem_rwen_d;
      mem_address_q   <= mem_address_d;
      mem_writedata_q <= mem_writedata_d;
    end
  end

  assign req_ready_o     = req_ready_q;
  assign rsp_valid_o     = rsp_valid_q;
  assign rsp_rdata_o     = rsp_rdata_q;
  assign rsp_fault_o     = rsp_fault_q;
  assign mem_rwen_o      = mem_rwen_q;
  assign mem_address_o   = mem_address_q;
  assign mem_writedata_o = mem_writedata_q;

endmodule
